// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable data width,
// oversample ratio, parity mode and stop-bit count.
// The whole design runs on the oversample clock 'baud'. 'reset' is asynchronous
// and active-high.
// Optional feature: define UART_RX_SYNC_EN to place a 2-flop synchronizer
// (reset value 1) on rx. This adds exactly two cycles of latency.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 baud,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 error
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic          ODD_MODE  = (PARITY == 1) ? 1'b1 : 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic                 rx_s;
    logic                 rx_prev_reg;
    logic                 start_edge;

    logic [2:0]           state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [3:0]           bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_err_reg, par_err_next;
    logic                 stop_err_reg, stop_err_next;
    logic                 finish_reg, finish_next;

    logic [DATA_BITS-1:0] data_reg;
    logic                 done_reg;
    logic                 parity_err_reg;
    logic                 frame_err_reg;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_reg;

    // Two-stage synchronizer. It idles high, so leaving reset never looks like a start edge.
    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];
`else
    assign rx_s = rx;
`endif

    // Edge-detect history. It tracks the line every cycle, including mid-frame,
    // so a line that stays low (break) cannot start a new frame.
    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            rx_prev_reg <= 1'b1;
        end else begin
            rx_prev_reg <= rx_s;
        end
    end

    assign start_edge = en & rx_prev_reg & ~rx_s;

    // Frame sequencer: next-state, tick/bit counters, shifter and error latches.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        par_err_next  = par_err_reg;
        stop_err_next = stop_err_reg;
        finish_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_M1) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        // A confirmed start clears the per-frame error latches.
                        state_next    = ST_DATA;
                        bit_next      = '0;
                        par_err_next  = 1'b0;
                        stop_err_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                    if (bit_reg == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next     = '0;
                    bit_next     = '0;
                    state_next   = ST_STOP;
                    // Odd mode wants an overall XOR of 1 and even mode wants 0.
                    par_err_next = (^shift_reg) ^ rx_s ^ ODD_MODE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        stop_err_next = 1'b1;
                    end
                    if (bit_reg == STOP_LAST) begin
                        // Return at mid-stop so a back-to-back start edge is seen.
                        state_next  = ST_IDLE;
                        bit_next    = '0;
                        finish_next = 1'b1;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                bit_next   = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            par_err_reg  <= 1'b0;
            stop_err_reg <= 1'b0;
            finish_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            par_err_reg  <= par_err_next;
            stop_err_reg <= stop_err_next;
            finish_reg   <= finish_next;
        end
    end

    // Result registers. They update together one cycle after the last stop
    // sample and hold until the next completed frame.
    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            data_reg       <= '0;
            done_reg       <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            done_reg <= finish_reg;
            if (finish_reg) begin
                data_reg       <= shift_reg;
                parity_err_reg <= par_err_reg;
                frame_err_reg  <= stop_err_reg;
            end
        end
    end

    assign data       = data_reg;
    assign done       = done_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign error      = parity_err_reg | frame_err_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed test of uart_rx_cfg with three instances:
// 8N1 defaults, even parity (PARITY=2), and two stop bits (STOP_BITS=2).
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int OVS = 16;
    localparam int H   = OVS / 2;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Detect edge to done: 8 + 16*9 + 1 for 8N1; 8 + 16*10 + 1 for 8E1 and 8N2.
    localparam int LAT_DEF = 153 + SYNC_LAT;
    localparam int LAT_PAR = 169 + SYNC_LAT;
    localparam int LAT_STP = 169 + SYNC_LAT;

    logic baud = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b1;
    logic rx_def = 1'b1, rx_par = 1'b1, rx_stp = 1'b1;

    logic [7:0] data_def, data_par, data_stp;
    logic done_def, busy_def, perr_def, ferr_def, err_def;
    logic done_par, busy_par, perr_par, ferr_par, err_par;
    logic done_stp, busy_stp, perr_stp, ferr_stp, err_stp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt_def = 0, done_cyc_def = 0, busy_cnt_def = 0;
    int done_cnt_par = 0, done_cyc_par = 0;
    int done_cnt_stp = 0, done_cyc_stp = 0;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(0), .STOP_BITS(1)) u_def (
        .baud(baud), .reset(reset), .en(en), .rx(rx_def), .data(data_def), .done(done_def),
        .busy(busy_def), .parity_err(perr_def), .frame_err(ferr_def), .error(err_def));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(2), .STOP_BITS(1)) u_par (
        .baud(baud), .reset(reset), .en(en), .rx(rx_par), .data(data_par), .done(done_par),
        .busy(busy_par), .parity_err(perr_par), .frame_err(ferr_par), .error(err_par));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(0), .STOP_BITS(2)) u_stp (
        .baud(baud), .reset(reset), .en(en), .rx(rx_stp), .data(data_stp), .done(done_stp),
        .busy(busy_stp), .parity_err(perr_stp), .frame_err(ferr_stp), .error(err_stp));

    always #5 baud = ~baud;

    always @(posedge baud) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge baud) begin
        if (done_def) begin done_cnt_def++; done_cyc_def = cyc; end
        if (done_par) begin done_cnt_par++; done_cyc_par = cyc; end
        if (done_stp) begin done_cnt_stp++; done_cyc_stp = cyc; end
        if (busy_def) busy_cnt_def++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge baud);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0: rx_def = v;
            1: rx_par = v;
            default: rx_stp = v;
        endcase
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic pbit, input int nstop, input logic [1:0] stops);
        set_rx(sel, 1'b0);
        start_cyc = cyc;
        tick(OVS);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            tick(OVS);
        end
        if (has_par) begin
            set_rx(sel, pbit);
            tick(OVS);
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(sel, stops[i]);
            tick(OVS);
        end
        set_rx(sel, 1'b1);
        $display("frame sent: line=%0d data=0x%02h parity=%0b stops=%0d/%02b", sel, d, pbit, nstop, stops);
    endtask

    task automatic test_reset;
        #2;
        reset = 1'b1;
        tick(3);
        checks++; if (data_def !== 8'h00) begin errors++; $display("FAIL reset_data: got 0x%02h expected 0x00", data_def); end
        checks++; if (done_def !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_def); end
        checks++; if (busy_def !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_def); end
        checks++; if ({perr_def, ferr_def, err_def} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {perr_def, ferr_def, err_def}); end
        checks++; if ({busy_par, busy_stp, done_par, done_stp} !== 4'b0000) begin errors++; $display("FAIL reset_others: got %b expected 0000", {busy_par, busy_stp, done_par, done_stp}); end
        checks++; if ({data_par, data_stp} !== 16'h0000) begin errors++; $display("FAIL reset_other_data: got 0x%04h expected 0x0000", {data_par, data_stp}); end
        reset = 1'b0;
        tick(3);
    endtask

    task automatic test_basic;
        int d0;
        d0 = done_cnt_def;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11);
        tick(8);
        checks++; if (done_cnt_def - d0 !== 1) begin errors++; $display("FAIL basic_done_cycles: got %0d expected 1", done_cnt_def - d0); end
        checks++; if (done_cyc_def - start_cyc - 1 !== LAT_DEF) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", done_cyc_def - start_cyc - 1, LAT_DEF); end
        checks++; if (data_def !== 8'hA5) begin errors++; $display("FAIL basic_data: got 0x%02h expected 0xa5", data_def); end
        checks++; if ({perr_def, ferr_def, err_def} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", {perr_def, ferr_def, err_def}); end
        checks++; if (busy_def !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy_def); end
    endtask

    task automatic test_parity;
        int d0;
        d0 = done_cnt_par;
        // 0x07 has three ones; even parity needs bit 1, so sending 0 is wrong.
        send_frame(1, 8'h07, 1'b1, 1'b0, 1, 2'b11);
        tick(8);
        checks++; if (done_cnt_par - d0 !== 1) begin errors++; $display("FAIL par_done: got %0d expected 1", done_cnt_par - d0); end
        checks++; if (done_cyc_par - start_cyc - 1 !== LAT_PAR) begin errors++; $display("FAIL par_latency: got %0d expected %0d", done_cyc_par - start_cyc - 1, LAT_PAR); end
        checks++; if (data_par !== 8'h07) begin errors++; $display("FAIL par_data: got 0x%02h expected 0x07", data_par); end
        checks++; if ({perr_par, ferr_par, err_par} !== 3'b101) begin errors++; $display("FAIL par_bad_flags: got %b expected 101", {perr_par, ferr_par, err_par}); end
        send_frame(1, 8'h07, 1'b1, 1'b1, 1, 2'b11);
        tick(8);
        checks++; if (done_cnt_par - d0 !== 2) begin errors++; $display("FAIL par_done2: got %0d expected 2", done_cnt_par - d0); end
        checks++; if ({perr_par, ferr_par, err_par} !== 3'b000) begin errors++; $display("FAIL par_good_flags: got %b expected 000", {perr_par, ferr_par, err_par}); end
    endtask

    task automatic test_stop2;
        int d0;
        d0 = done_cnt_stp;
        send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 2'b01);
        tick(8);
        checks++; if (done_cnt_stp - d0 !== 1) begin errors++; $display("FAIL stop2_done: got %0d expected 1", done_cnt_stp - d0); end
        checks++; if (done_cyc_stp - start_cyc - 1 !== LAT_STP) begin errors++; $display("FAIL stop2_latency: got %0d expected %0d", done_cyc_stp - start_cyc - 1, LAT_STP); end
        checks++; if (data_stp !== 8'h3C) begin errors++; $display("FAIL stop2_data: got 0x%02h expected 0x3c", data_stp); end
        checks++; if ({perr_stp, ferr_stp, err_stp} !== 3'b011) begin errors++; $display("FAIL stop2_flags: got %b expected 011", {perr_stp, ferr_stp, err_stp}); end
        send_frame(2, 8'hC3, 1'b0, 1'b0, 2, 2'b11);
        tick(8);
        checks++; if ({data_stp, ferr_stp, err_stp} !== {8'hC3, 2'b00}) begin errors++; $display("FAIL stop2_good: got 0x%02h/%b expected 0xc3/00", data_stp, {ferr_stp, err_stp}); end
    endtask

    task automatic test_false_start;
        int d0, b0;
        d0 = done_cnt_def;
        b0 = busy_cnt_def;
        set_rx(0, 1'b0);
        tick(3);
        set_rx(0, 1'b1);
        tick(40);
        checks++; if (busy_cnt_def - b0 > H || busy_cnt_def - b0 < 1) begin errors++; $display("FAIL false_busy_cycles: got %0d expected 1..%0d", busy_cnt_def - b0, H); end
        checks++; if (done_cnt_def - d0 !== 0) begin errors++; $display("FAIL false_done: got %0d expected 0", done_cnt_def - d0); end
        checks++; if ({data_def, perr_def, ferr_def, err_def} !== {8'hA5, 3'b000}) begin errors++; $display("FAIL false_outputs: got 0x%02h/%b expected 0xa5/000", data_def, {perr_def, ferr_def, err_def}); end
    endtask

    task automatic test_reset_mid;
        int d0;
        logic [7:0] d;
        d = 8'h55;
        d0 = done_cnt_def;
        set_rx(0, 1'b0);
        tick(OVS);
        for (int i = 0; i < 4; i++) begin
            set_rx(0, d[i]);
            tick(OVS);
        end
        set_rx(0, d[4]);
        tick(4);
        reset = 1'b1;
        #1;
        checks++; if (busy_def !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b expected 0", busy_def); end
        tick(2);
        checks++; if (data_def !== 8'h00) begin errors++; $display("FAIL reset_mid_data: got 0x%02h expected 0x00", data_def); end
        set_rx(0, 1'b1);
        reset = 1'b0;
        tick(200);
        checks++; if (done_cnt_def - d0 !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d expected 0", done_cnt_def - d0); end
        send_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b11);
        tick(8);
        checks++; if (done_cnt_def - d0 !== 1) begin errors++; $display("FAIL reset_mid_done: got %0d expected 1", done_cnt_def - d0); end
        checks++; if (data_def !== 8'h81) begin errors++; $display("FAIL reset_mid_data2: got 0x%02h expected 0x81", data_def); end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt_def;
        en = 1'b1;
        // en drops mid-frame and must not abort it; it comes back before the next start.
        fork
            send_frame(0, 8'h12, 1'b0, 1'b0, 1, 2'b11);
            begin
                tick(5);
                en = 1'b0;
                tick(OVS * 8);
                en = 1'b1;
            end
        join
        checks++; if (done_cnt_def - d0 !== 1) begin errors++; $display("FAIL b2b_done1: got %0d expected 1", done_cnt_def - d0); end
        checks++; if (data_def !== 8'h12) begin errors++; $display("FAIL b2b_data1: got 0x%02h expected 0x12", data_def); end
        fork
            send_frame(0, 8'h34, 1'b0, 1'b0, 1, 2'b11);
            begin
                tick(5);
                en = 1'b0;
            end
        join
        tick(8);
        checks++; if (done_cnt_def - d0 !== 2) begin errors++; $display("FAIL b2b_done2: got %0d expected 2", done_cnt_def - d0); end
        checks++; if (data_def !== 8'h34) begin errors++; $display("FAIL b2b_data2: got 0x%02h expected 0x34", data_def); end
        send_frame(0, 8'h56, 1'b0, 1'b0, 1, 2'b11);
        tick(20);
        checks++; if (done_cnt_def - d0 !== 2) begin errors++; $display("FAIL b2b_third_ignored: got %0d expected 2", done_cnt_def - d0); end
        checks++; if ({data_def, busy_def} !== {8'h34, 1'b0}) begin errors++; $display("FAIL b2b_third_outputs: got 0x%02h/%b expected 0x34/0", data_def, busy_def); end
        en = 1'b1;
        tick(2);
    endtask

    task automatic test_break;
        int d0;
        d0 = done_cnt_def;
        set_rx(0, 1'b0);
        tick(OVS * 12);
        checks++; if (done_cnt_def - d0 !== 1) begin errors++; $display("FAIL break_done: got %0d expected 1", done_cnt_def - d0); end
        checks++; if ({data_def, ferr_def, err_def} !== {8'h00, 2'b11}) begin errors++; $display("FAIL break_outputs: got 0x%02h/%b expected 0x00/11", data_def, {ferr_def, err_def}); end
        checks++; if (busy_def !== 1'b0) begin errors++; $display("FAIL break_no_restart: got busy=%b expected 0", busy_def); end
        set_rx(0, 1'b1);
        tick(OVS * 2);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 2'b11);
        tick(8);
        checks++; if ({data_def, ferr_def, err_def} !== {8'h5A, 2'b00}) begin errors++; $display("FAIL break_recover: got 0x%02h/%b expected 0x5a/00", data_def, {ferr_def, err_def}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_false_start();
        test_reset_mid();
        test_back_to_back();
        test_break();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit (even, legal 4..64).
REQ-003 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (legal 1..2).
REQ-005 SHALL have port baud  input  1  sole clock, rising edge, running at OVERSAMPLE x bit rate.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  input  1  enables detection of a new start bit.
REQ-008 SHALL have port rx  input  1  serial line, idle high, LSB first.
REQ-009 SHALL have port data  output  DATA_BITS  last received data word.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of each completed frame.
REQ-011 SHALL have port busy  output  1  frame reception in progress.
REQ-012 SHALL have port parity_err  output  1  parity mismatch in last completed frame.
REQ-013 SHALL have port frame_err  output  1  a stop bit sampled low in last completed frame.
REQ-014 SHALL have port error  output  1  OR of parity_err and frame_err.

Function
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-016 IDLE->START SHALL occur only on en=1 and a falling edge of the sampled rx (previous 1, current 0); tick counter cleared.
REQ-017 START SHALL resample rx at tick OVERSAMPLE/2-1: low -> DATA, counter cleared; high -> IDLE (false start, no done, no flag change).
REQ-018 DATA SHALL sample rx every OVERSAMPLE ticks at mid-bit, shifting LSB first; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-019 PARITY SHALL sample one bit; odd mode expects XOR(data,parity bit)=1, even mode expects 0; mismatch latched internally.
REQ-020 STOP SHALL sample STOP_BITS bits at mid-bit; any low sample latched as frame error; after last sample -> IDLE.
REQ-021 On the cycle after the last stop sample, data, parity_err, frame_err SHALL update together and done SHALL be high for exactly one cycle.
REQ-022 data and error flags SHALL hold until the next completed frame; false starts SHALL NOT alter them.
REQ-023 Latency: done SHALL assert OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+(PARITY!=0)+STOP_BITS) + 1 cycles after the detecting edge.
REQ-024 en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-025 Break (rx held low): frame completes with frame_err=1, data=0; no new start until rx has been seen high.
REQ-026 Return to IDLE at mid-stop SHALL allow a back-to-back start edge to be detected with no lost frame.

Reset
REQ-027 reset SHALL asynchronously force state=IDLE, counters=0, data=0, done=0, busy=0, parity_err=0, frame_err=0, error=0, edge-detect history=1.
REQ-028 reset mid-frame SHALL discard the partial frame with no done pulse after release.

Configuration
REQ-029 With UART_RX_SYNC_EN defined, rx SHALL pass a 2-flop synchronizer (reset value 1) before edge detect and sampling, adding exactly 2 cycles to REQ-023 latency.
REQ-030 Without UART_RX_SYNC_EN, rx SHALL be used directly and REQ-023 latency applies unchanged.

Verification
REQ-031 Defaults (8N1, OVS 16), send 0xA5 -> data=0xA5, done high 1 cycle at REQ-023 count, error=0.
REQ-032 PARITY=2, send 0x07 with parity bit 0 -> parity_err=1, error=1, data=0x07; next good frame clears it.
REQ-033 STOP_BITS=2, second stop bit low, byte 0x3C -> frame_err=1, data=0x3C.
REQ-034 rx low pulse of 3 ticks in IDLE -> busy for <=OVERSAMPLE/2 cycles, no done, outputs unchanged.
REQ-035 reset asserted at bit 4 of frame 0x55, then clean frame 0x81 -> only one done, data=0x81.
REQ-036 Two back-to-back frames 0x12, 0x34 with en low after first start edge -> both done pulses; third frame ignored.
